// File: rtl/pong_uart_cmd.sv
// pong_uart_cmd: UART receiver (8N1; 8E1 with PONG_UART_PARITY_EN) plus Pong command decoder.
// Ports: clk, rst_n (async low); uart_rx in; rx_data/rx_valid, frame_err, parity_err,
//   p1_up/p1_down/p2_up/p2_down (held levels), paused (level), game_reset (pulse).
// Optional feature macro: PONG_UART_PARITY_EN (even-parity bit between data and stop).
module pong_uart_cmd #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HOLD_CLKS    = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p2_up,
  output logic       p2_down,
  output logic       paused,
  output logic       game_reset
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HW = $clog2(HOLD_CLKS + 1);
  localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [HW-1:0] HLOAD = HW'(HOLD_CLKS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
`ifdef PONG_UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_POST   = S_PARITY;
`else
  localparam logic [2:0] S_POST   = S_STOP;
`endif

  logic          r_sync1, r_sync2;
  logic          w_rx;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;
  logic          w_par_bad;
`ifdef PONG_UART_PARITY_EN
  logic          r_par;
  logic          r_perr;
  assign w_par_bad  = ^{r_shift, r_par};
  assign parity_err = r_perr;
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign w_rx = r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef PONG_UART_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef PONG_UART_PARITY_EN
      r_perr  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (!w_rx) r_state <= S_START;
        end
        S_START: begin
          if (r_cnt == HALF) begin
            r_cnt   <= '0;
            // a high mid-start sample is a glitch, not a frame
            r_state <= w_rx ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= S_POST;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef PONG_UART_PARITY_EN
        S_PARITY: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_par   <= w_rx;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (r_cnt == LAST) begin
            r_cnt <= '0;
            if (!w_rx) begin
              r_ferr  <= 1'b1;
              r_state <= S_WAIT;
            end else if (w_par_bad) begin
`ifdef PONG_UART_PARITY_EN
              r_perr  <= 1'b1;
`endif
              r_state <= S_IDLE;
            end else begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (w_rx) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // bit 5 folds ASCII case; only the two letter codes map onto each key
  logic [7:0] w_lc;
  logic       w_w, w_s, w_i, w_k, w_p, w_r;
  assign w_lc = r_data | 8'h20;
  assign w_w  = r_valid && (w_lc == 8'h77);
  assign w_s  = r_valid && (w_lc == 8'h73);
  assign w_i  = r_valid && (w_lc == 8'h69);
  assign w_k  = r_valid && (w_lc == 8'h6b);
  assign w_p  = r_valid && (w_lc == 8'h70);
  assign w_r  = r_valid && (w_lc == 8'h72);

  logic [HW-1:0] r_hold1, r_hold2;
  logic          r_p1u, r_p1d, r_p2u, r_p2d;
  logic          r_pause, r_grst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold1 <= '0;
      r_hold2 <= '0;
      r_p1u   <= 1'b0;
      r_p1d   <= 1'b0;
      r_p2u   <= 1'b0;
      r_p2d   <= 1'b0;
      r_pause <= 1'b0;
      r_grst  <= 1'b0;
    end else begin
      r_grst <= w_r;
      if (w_p)      r_pause <= ~r_pause;
      else if (w_r) r_pause <= 1'b0;

      if (w_w || w_s) begin
        r_hold1 <= HLOAD;
        r_p1u   <= w_w;
        r_p1d   <= w_s;
      end else if (r_hold1 != '0) begin
        r_hold1 <= r_hold1 - 1'b1;
      end else begin
        r_p1u <= 1'b0;
        r_p1d <= 1'b0;
      end

      if (w_i || w_k) begin
        r_hold2 <= HLOAD;
        r_p2u   <= w_i;
        r_p2d   <= w_k;
      end else if (r_hold2 != '0) begin
        r_hold2 <= r_hold2 - 1'b1;
      end else begin
        r_p2u <= 1'b0;
        r_p2d <= 1'b0;
      end
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign frame_err  = r_ferr;
  assign p1_up      = r_p1u;
  assign p1_down    = r_p1d;
  assign p2_up      = r_p2u;
  assign p2_down    = r_p2d;
  assign paused     = r_pause;
  assign game_reset = r_grst;
endmodule

// File: tb/tb_pong_uart_cmd.sv
// tb_pong_uart_cmd: directed bench for pong_uart_cmd (CLKS_PER_BIT=16, HOLD_CLKS=100).
// A negedge monitor tallies pulses and edge cycles; the main sequence checks them.
module tb_pong_uart_cmd;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err;
  logic       p1_up, p1_down, p2_up, p2_down, paused, game_reset;

  pong_uart_cmd #(.CLKS_PER_BIT(16), .HOLD_CLKS(100)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .parity_err(parity_err),
    .p1_up(p1_up), .p1_down(p1_down),
    .p2_up(p2_up), .p2_down(p2_down),
    .paused(paused), .game_reset(game_reset)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  int cyc = 0, n_valid = 0, n_ferr = 0, n_perr = 0;
  int n_grst = 0, n_both = 0, n_p1d = 0, last_vcyc = 0;
  int p1u_rise = 0, p1u_fall = 0, p1d_rise = 0, p2u_rise = 0, p2d_rise = 0;
  logic [7:0] last_data = 8'h00;
  logic pv1u = 0, pv1d = 0, pv2u = 0, pv2d = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_valid) begin
      n_valid = n_valid + 1;
      last_vcyc = cyc;
      last_data = rx_data;
    end
    if (frame_err) n_ferr = n_ferr + 1;
    if (parity_err) n_perr = n_perr + 1;
    if (game_reset) n_grst = n_grst + 1;
    if (p1_down) n_p1d = n_p1d + 1;
    if ((p1_up && p1_down) || (p2_up && p2_down)) n_both = n_both + 1;
    if (p1_up && !pv1u) p1u_rise = cyc;
    if (!p1_up && pv1u) p1u_fall = cyc;
    if (p1_down && !pv1d) p1d_rise = cyc;
    if (p2_up && !pv2u) p2u_rise = cyc;
    if (p2_down && !pv2d) p2d_rise = cyc;
    pv1u = p1_up; pv1d = p1_down; pv2u = p2_up; pv2d = p2_down;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit,
                      input logic par_flip);
    uart_rx = 1'b0;
    idle(16);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(16);
    end
`ifdef PONG_UART_PARITY_EN
    uart_rx = (^b) ^ par_flip;
    idle(16);
`else
    if (par_flip) idle(0);
`endif
    uart_rx = stop_bit;
    idle(16);
  endtask

  function automatic logic [8:0] outs();
    return {rx_valid, frame_err, parity_err, p1_up, p1_down,
            p2_up, p2_down, paused, game_reset};
  endfunction

  int sv, sf, sp, sg, sd;

  initial begin
    idle(3);
    check("reset_outs", {23'd0, outs()}, 32'd0);
    check("reset_data", rx_data, 8'h00);
    rst_n = 1'b1;
    idle(5);

    // 'w': one valid, p1_up 1 cycle after rx_valid, held 100 cycles
    sv = n_valid; sd = n_p1d;
    send(8'h77, 1'b1, 1'b0);
    idle(120);
    check("w_valid_cnt", n_valid - sv, 1);
    check("w_data", last_data, 8'h77);
    check("w_up_latency", p1u_rise - last_vcyc, 1);
    check("w_hold_len", p1u_fall - p1u_rise, 100);
    check("w_no_down", n_p1d - sd, 0);

    // 'w' then 'S' back to back
    send(8'h77, 1'b1, 1'b0);
    send(8'h53, 1'b1, 1'b0);
    idle(4);
    check("s_data", last_data, 8'h53);
    check("s_down_latency", p1d_rise - last_vcyc, 1);
    check("s_up_low", p1_up, 1'b0);
    check("s_down_high", p1_down, 1'b1);
    idle(120);

    // 4-cycle glitch
    sv = n_valid; sf = n_ferr;
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(40);
    check("glitch_valid", n_valid - sv, 0);
    check("glitch_ferr", n_ferr - sf, 0);
    send(8'h4b, 1'b1, 1'b0);
    idle(4);
    check("k_data", last_data, 8'h4b);
    check("k_down_latency", p2d_rise - last_vcyc, 1);
    idle(120);

    // 0x41 with low stop, line held low for 50 bits
    sv = n_valid; sf = n_ferr;
    send(8'h41, 1'b0, 1'b0);
    idle(16 * 49);
    uart_rx = 1'b1;
    idle(32);
    check("brk_ferr", n_ferr - sf, 1);
    check("brk_valid", n_valid - sv, 0);
    send(8'h70, 1'b1, 1'b0);
    idle(4);
    check("brk_p_data", last_data, 8'h70);
    check("brk_p_paused", paused, 1'b1);

    // pause toggling and reset command
    send(8'h70, 1'b1, 1'b0); idle(4);
    check("p1_paused", paused, 1'b0);
    send(8'h70, 1'b1, 1'b0); idle(4);
    check("p2_paused", paused, 1'b1);
    send(8'h70, 1'b1, 1'b0); idle(4);
    check("p3_paused", paused, 1'b0);
    send(8'h50, 1'b1, 1'b0); idle(4);
    check("P_paused", paused, 1'b1);
    sg = n_grst;
    send(8'h72, 1'b1, 1'b0); idle(4);
    check("r_paused", paused, 1'b0);
    check("r_grst_len", n_grst - sg, 1);

    // reset asserted during data bit 3 of 'i'
    send(8'h57, 1'b1, 1'b0);
    uart_rx = 1'b0; idle(16);
    for (int i = 0; i < 3; i++) begin
      uart_rx = (i == 0) ? 1'b1 : 1'b0;
      idle(16);
    end
    uart_rx = 1'b1; idle(8);
    check("pre_rst_p1up", p1_up, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_outs", {23'd0, outs()}, 32'd0);
    check("rst_data", rx_data, 8'h00);
    idle(3);
    rst_n = 1'b1;
    sv = n_valid;
    idle(200);
    check("post_rst_valid", n_valid - sv, 0);
    check("post_rst_outs", {23'd0, outs()}, 32'd0);
    send(8'h69, 1'b1, 1'b0);
    idle(4);
    check("i_data", last_data, 8'h69);
    check("i_up_latency", p2u_rise - last_vcyc, 1);
    check("i_p2up", p2_up, 1'b1);
    idle(120);

`ifdef PONG_UART_PARITY_EN
    sv = n_valid; sp = n_perr;
    send(8'h57, 1'b1, 1'b1);
    idle(4);
    check("par_err", n_perr - sp, 1);
    check("par_valid", n_valid - sv, 0);
    check("par_p1up", p1_up, 1'b0);
`else
    sp = 0;
    check("no_par_err", n_perr - sp, 0);
`endif
    check("never_both", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
